// File: rtl/cursor_navigator.sv
// cursor_navigator: 9x9 grid cursor, 1..9 digit select and write/clear strobes from controller levels.
// Held-direction auto-repeat is built only when CURSOR_NAVIGATOR_AUTOREPEAT_EN is defined.
module cursor_navigator #(
   parameter int DELAY_CYCLES = 20000000,
   parameter int RATE_CYCLES  = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up,
   input  logic       dw,
   input  logic       lf,
   input  logic       rg,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       st,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] digit,
   output logic       write_pulse,
   output logic       clear_pulse,
   output logic       move_pulse
);
   logic [7:0] s1, s2, pv, evt;
   logic [3:0] held, row_n, col_n, digit_n;
   logic       p_v, step_v, act_evt, apply_v, pend_v;
   logic [1:0] p_dir, step_dir, apply_dir, pend_dir;

   assign evt       = s2 & ~pv;
   assign held      = s2[3:0];
   assign p_v       = |evt[3:0];
   assign p_dir     = evt[0] ? 2'd0 : evt[1] ? 2'd1 : evt[2] ? 2'd2 : 2'd3;
   assign act_evt   = evt[6] | evt[7];
   // A step coinciding with a write/clear is held back one cycle so the strobe sees the old cell.
   assign apply_v   = pend_v | (step_v & ~act_evt);
   assign apply_dir = pend_v ? pend_dir : step_dir;

   always_comb begin
      row_n   = row;
      col_n   = col;
      digit_n = digit;
      if (apply_v) begin
         row_n = apply_dir == 2'd0 ? (row == 4'd0 ? 4'd8 : row - 4'd1) :
                 apply_dir == 2'd1 ? (row == 4'd8 ? 4'd0 : row + 4'd1) : row;
         col_n = apply_dir == 2'd2 ? (col == 4'd0 ? 4'd8 : col - 4'd1) :
                 apply_dir == 2'd3 ? (col == 4'd8 ? 4'd0 : col + 4'd1) : col;
      end
      digit_n = (evt[4] & ~evt[5]) ? (digit == 4'd9 ? 4'd1 : digit + 4'd1) :
                (evt[5] & ~evt[4]) ? (digit == 4'd1 ? 4'd9 : digit - 4'd1) : digit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1          <= '0;
         s2          <= '0;
         pv          <= '0;
         row         <= 4'd0;
         col         <= 4'd0;
         digit       <= 4'd1;
         write_pulse <= 1'b0;
         clear_pulse <= 1'b0;
         move_pulse  <= 1'b0;
         pend_v      <= 1'b0;
         pend_dir    <= 2'd0;
      end else begin
         s1          <= {st, c, b, a, rg, lf, dw, up};
         s2          <= s1;
         pv          <= s2;
         row         <= row_n;
         col         <= col_n;
         digit       <= digit_n;
         write_pulse <= evt[6] & ~evt[7];
         clear_pulse <= evt[7];
         move_pulse  <= apply_v;
         pend_v      <= step_v & (act_evt | pend_v);
         pend_dir    <= step_dir;
      end
   end

`ifdef CURSOR_NAVIGATOR_AUTOREPEAT_EN
   localparam int MAXC = DELAY_CYCLES > RATE_CYCLES ? DELAY_CYCLES : RATE_CYCLES;
   localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] D_LAST = CW'(DELAY_CYCLES - 1);
   localparam logic [CW-1:0] R_LAST = CW'(RATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    dir, dir_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         dir   <= 2'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dir   <= dir_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt + 1'b1;
      dir_n    = dir;
      step_v   = 1'b0;
      step_dir = dir;
      if (state == IDLE) begin
         cnt_n = '0;
         if (p_v) begin
            step_v   = 1'b1;
            step_dir = p_dir;
            dir_n    = p_dir;
            state_n  = DELAY;
         end
      end else if (p_v && p_dir != dir) begin
         step_v   = 1'b1;
         step_dir = p_dir;
         dir_n    = p_dir;
         cnt_n    = '0;
         state_n  = DELAY;
      end else if (!held[dir]) begin
         cnt_n   = '0;
         state_n = IDLE;
      end else if (cnt == (state == DELAY ? D_LAST : R_LAST)) begin
         step_v  = 1'b1;
         cnt_n   = '0;
         state_n = REPEAT;
      end
   end
`else
   assign step_v   = p_v;
   assign step_dir = p_dir;
`endif
endmodule
